fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard controller for the integer pipeline. It generalises the fixed two-stage, four-byte-lane forwarding logic into a depth-configurable unit.
- Keeps an internal shift-register scoreboard of in-flight producers. Ages it every cycle.
- Per source operand and per byte lane, selects the youngest ready producer.
- Raises a load-use stall for producers whose data is not ready and counts stall cycles. Sits beside the decode stage and drives the EX operand-mux selects.

---
 rtl/fwd_hazard_unit.sv | 159 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//
// Forwarding and load-use hazard controller that sits beside the decode stage.
// It keeps a shift-register record of in-flight producers: entry 0 is the EX
// stage and entry DEPTH-1 is the oldest stage. For each source operand and each
// byte lane it picks the youngest producer that writes that lane. It stalls
// decode when that producer is a load whose data is not yet available.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   id_valid         decode holds a real instruction
//   id_rs, id_rt     source register indices (operand A / operand B)
//   id_rd, id_we     destination index and write enable
//   id_be            byte lanes written by the decode instruction
//   id_load          decode instruction is a load
//   flush            squash all in-flight entries and the decode instruction
//   stall            hold IF/ID (combinational)
//   rs_sel, rt_sel   per-lane mux selects, lane k at [k*SELW +: SELW];
//                    0 = register file, i+1 = scoreboard entry i
//   ex_valid         entry 0 holds a real instruction
//   stall_cnt        saturating count of stall cycles
module fwd_hazard_unit #(
  parameter int RBITS    = 5,
  parameter int LANES    = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [RBITS-1:0]      id_rs,
  input  logic [RBITS-1:0]      id_rt,
  input  logic [RBITS-1:0]      id_rd,
  input  logic                  id_we,
  input  logic [LANES-1:0]      id_be,
  input  logic                  id_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [LANES*SELW-1:0] rs_sel,
  output logic [LANES*SELW-1:0] rt_sel,
  output logic                  ex_valid,
  output logic [15:0]           stall_cnt
);

  // Scoreboard entries, index 0 = youngest (EX), DEPTH-1 = oldest.
  logic [DEPTH-1:0] ent_v;
  logic [DEPTH-1:0] ent_we;
  logic [DEPTH-1:0] ent_ld;
  logic [RBITS-1:0] ent_rd [DEPTH];
  logic [LANES-1:0] ent_be [DEPTH];

  logic [DEPTH-1:0] is_prod;
  logic [LANES-1:0] rs_blk;
  logic [LANES-1:0] rt_blk;
  logic             rs_hit;
  logic             rt_hit;

  // An entry only counts as a producer when it really writes a non-zero
  // register. Because rd != 0 is required here, a source of r0 can never
  // match and always falls back to the register file.
  always_comb begin
    is_prod = '0;
    for (int i = 0; i < DEPTH; i++) begin
      is_prod[i] = ent_v[i] && ent_we[i] && (ent_rd[i] != '0);
    end
  end

  // Per-lane youngest-match search. The hit flags stop the scan at the first
  // matching entry. When that entry is a load that is still too young, the
  // lane is blocked and older entries must not be used: their data is stale.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    rs_blk = '0;
    rt_blk = '0;
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!rs_hit && is_prod[i] && (ent_rd[i] == id_rs) && ent_be[i][k]) begin
          rs_hit = 1'b1;
          if (ent_ld[i] && (i < LOAD_LAT)) begin
            rs_blk[k] = 1'b1;
          end else begin
            rs_sel[k*SELW +: SELW] = SELW'(i + 1);
          end
        end
        if (!rt_hit && is_prod[i] && (ent_rd[i] == id_rt) && ent_be[i][k]) begin
          rt_hit = 1'b1;
          if (ent_ld[i] && (i < LOAD_LAT)) begin
            rt_blk[k] = 1'b1;
          end else begin
            rt_sel[k*SELW +: SELW] = SELW'(i + 1);
          end
        end
      end
    end
  end

  assign stall    = id_valid && !flush && ((|rs_blk) || (|rt_blk));
  assign ex_valid = ent_v[0];

  // Each cycle the entries age by one stage. A stall inserts a bubble behind
  // the load, so the load simply walks towards LOAD_LAT and the stall
  // releases on its own without any extra state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v  <= '0;
      ent_we <= '0;
      ent_ld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i] <= '0;
        ent_be[i] <= '0;
      end
    end else if (flush) begin
      ent_v  <= '0;
      ent_we <= '0;
      ent_ld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i] <= '0;
        ent_be[i] <= '0;
      end
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        ent_v[i]  <= ent_v[i-1];
        ent_we[i] <= ent_we[i-1];
        ent_ld[i] <= ent_ld[i-1];
        ent_rd[i] <= ent_rd[i-1];
        ent_be[i] <= ent_be[i-1];
      end
      if (stall) begin
        ent_v[0]  <= 1'b0;
        ent_we[0] <= 1'b0;
        ent_ld[0] <= 1'b0;
        ent_rd[0] <= '0;
        ent_be[0] <= '0;
      end else begin
        ent_v[0]  <= id_valid;
        ent_we[0] <= id_we;
        ent_ld[0] <= id_load;
        ent_rd[0] <= id_rd;
        ent_be[0] <= id_be;
      end
    end
  end

  // Flush does not clear the counter; only reset does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//
// Bench for fwd_hazard_unit. It uses three instances:
//   dut_a : default parameters (DEPTH=3, LOAD_LAT=1), directed and random tests
//   dut_b : DEPTH=5, LOAD_LAT=3, multi-cycle load-use stall
//   dut_c : DEPTH=16, LOAD_LAT=15, stall counter saturation
// dut_b and dut_c share one set of inputs and one reset.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic       a_rst_n, a_valid, a_we, a_ld, a_flush;
  logic [4:0] a_rs, a_rt, a_rd;
  logic [3:0] a_be;
  logic       a_stall, a_ex_valid;
  logic [7:0] a_rs_sel, a_rt_sel;
  logic [15:0] a_stall_cnt;

  // Shared instance B/C inputs
  logic       bc_rst_n, bc_valid, bc_we, bc_ld, bc_flush;
  logic [4:0] bc_rs, bc_rt, bc_rd;
  logic [3:0] bc_be;

  logic        b_stall, b_ex_valid;
  logic [11:0] b_rs_sel, b_rt_sel;
  logic [15:0] b_stall_cnt;
  logic        c_stall, c_ex_valid;
  logic [19:0] c_rs_sel, c_rt_sel;
  logic [15:0] c_stall_cnt;

  fwd_hazard_unit dut_a (
    .clk(clk), .rst_n(a_rst_n), .id_valid(a_valid), .id_rs(a_rs), .id_rt(a_rt),
    .id_rd(a_rd), .id_we(a_we), .id_be(a_be), .id_load(a_ld), .flush(a_flush),
    .stall(a_stall), .rs_sel(a_rs_sel), .rt_sel(a_rt_sel),
    .ex_valid(a_ex_valid), .stall_cnt(a_stall_cnt)
  );

  fwd_hazard_unit #(.DEPTH(5), .LOAD_LAT(3)) dut_b (
    .clk(clk), .rst_n(bc_rst_n), .id_valid(bc_valid), .id_rs(bc_rs), .id_rt(bc_rt),
    .id_rd(bc_rd), .id_we(bc_we), .id_be(bc_be), .id_load(bc_ld), .flush(bc_flush),
    .stall(b_stall), .rs_sel(b_rs_sel), .rt_sel(b_rt_sel),
    .ex_valid(b_ex_valid), .stall_cnt(b_stall_cnt)
  );

  fwd_hazard_unit #(.DEPTH(16), .LOAD_LAT(15)) dut_c (
    .clk(clk), .rst_n(bc_rst_n), .id_valid(bc_valid), .id_rs(bc_rs), .id_rt(bc_rt),
    .id_rd(bc_rd), .id_we(bc_we), .id_be(bc_be), .id_load(bc_ld), .flush(bc_flush),
    .stall(c_stall), .rs_sel(c_rs_sel), .rt_sel(c_rt_sel),
    .ex_valid(c_ex_valid), .stall_cnt(c_stall_cnt)
  );

  // Reference model for dut_a: a list of in-flight instructions indexed by
  // age in cycles since issue (0 = just issued into EX).
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit [3:0] be;
    bit       ld;
  } rec_t;

  localparam int M_DEPTH = 3;
  localparam int M_LL    = 1;

  rec_t pipe [M_DEPTH];
  int   m_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int unit, input logic valid, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic we,
                               input logic [3:0] be, input logic ld, input logic fl);
    if (unit == 0) begin
      a_valid = valid; a_rs = rs; a_rt = rt; a_rd = rd;
      a_we = we; a_be = be; a_ld = ld; a_flush = fl;
    end else begin
      bc_valid = valid; bc_rs = rs; bc_rt = rt; bc_rd = rd;
      bc_we = we; bc_be = be; bc_ld = ld; bc_flush = fl;
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Youngest writer of each byte lane decides where that lane comes from;
  // a load younger than M_LL cycles has no data yet, so the lane blocks.
  function automatic void modelSel(input logic [4:0] src, output logic [7:0] sel,
                                   output logic blk);
    sel = '0;
    blk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int age = 0; age < M_DEPTH; age++) begin
        if (src != 0 && pipe[age].v && pipe[age].we && pipe[age].rd == src &&
            pipe[age].be[k]) begin
          if (pipe[age].ld && age < M_LL) blk = 1'b1;
          else sel[k*2 +: 2] = 2'(age + 1);
          break;
        end
      end
    end
  endfunction

  initial begin
    logic [7:0] e_rs, e_rt;
    logic       blk_s, blk_t, e_stall;
    logic       r_valid, r_we, r_ld, r_fl;
    logic [4:0] r_rs, r_rt, r_rd;
    logic [3:0] r_be;

    a_rst_n = 1'b0;
    bc_rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    checkOutput("reset_stall", 32'(a_stall), 32'd0);
    checkOutput("reset_rs_sel", 32'(a_rs_sel), 32'd0);
    checkOutput("reset_rt_sel", 32'(a_rt_sel), 32'd0);
    checkOutput("reset_ex_valid", 32'(a_ex_valid), 32'd0);
    checkOutput("reset_stall_cnt", 32'(a_stall_cnt), 32'd0);
    a_rst_n = 1'b1;
    bc_rst_n = 1'b1;
    @(negedge clk);

    // ALU back-to-back: add r3, then two consumers of r3
    applyStimulus(0, 1, 0, 0, 3, 1, 4'hF, 0, 0);
    #1 checkOutput("alu_issue_stall", 32'(a_stall), 32'd0);
    stepCycle();
    applyStimulus(0, 1, 3, 0, 0, 0, 4'h0, 0, 0);
    #1;
    checkOutput("alu_ex_sel", 32'(a_rs_sel), 32'h55);
    checkOutput("alu_ex_stall", 32'(a_stall), 32'd0);
    checkOutput("alu_ex_valid", 32'(a_ex_valid), 32'd1);
    stepCycle();
    #1 checkOutput("alu_mem_sel", 32'(a_rs_sel), 32'hAA);
    stepCycle();

    // Load-use: lw r5, then consumer on rt
    applyStimulus(0, 1, 0, 0, 5, 1, 4'hF, 1, 0);
    stepCycle();
    applyStimulus(0, 1, 0, 5, 0, 0, 4'h0, 0, 0);
    #1;
    checkOutput("lu_stall", 32'(a_stall), 32'd1);
    checkOutput("lu_blocked_sel", 32'(a_rt_sel), 32'd0);
    checkOutput("lu_cnt_before", 32'(a_stall_cnt), 32'd0);
    stepCycle();
    #1;
    checkOutput("lu_release_stall", 32'(a_stall), 32'd0);
    checkOutput("lu_release_sel", 32'(a_rt_sel), 32'hAA);
    checkOutput("lu_cnt_after", 32'(a_stall_cnt), 32'd1);
    stepCycle();

    // Byte merge: lw r7 all lanes, then byte store to r7 lane 0
    applyStimulus(0, 1, 0, 0, 7, 1, 4'hF, 1, 0);
    stepCycle();
    applyStimulus(0, 1, 0, 0, 7, 1, 4'h1, 0, 0);
    stepCycle();
    applyStimulus(0, 1, 7, 0, 0, 0, 4'h0, 0, 0);
    #1;
    checkOutput("merge_sel", 32'(a_rs_sel), 32'hA9);
    checkOutput("merge_stall", 32'(a_stall), 32'd0);
    stepCycle();

    // r0 destination and a disabled write never forward
    applyStimulus(0, 1, 0, 0, 0, 1, 4'hF, 0, 0);
    stepCycle();
    applyStimulus(0, 1, 0, 0, 4, 0, 4'hF, 0, 0);
    stepCycle();
    applyStimulus(0, 1, 0, 4, 0, 0, 4'h0, 0, 0);
    #1;
    checkOutput("r0_rs_sel", 32'(a_rs_sel), 32'd0);
    checkOutput("nowe_rt_sel", 32'(a_rt_sel), 32'd0);
    checkOutput("r0_stall", 32'(a_stall), 32'd0);
    stepCycle();

    // Flush during a load-use stall
    applyStimulus(0, 1, 0, 0, 2, 1, 4'hF, 1, 0);
    stepCycle();
    applyStimulus(0, 1, 2, 0, 0, 0, 4'h0, 0, 0);
    #1 checkOutput("flush_pre_stall", 32'(a_stall), 32'd1);
    a_flush = 1'b1;
    #1 checkOutput("flush_stall", 32'(a_stall), 32'd0);
    stepCycle();
    applyStimulus(0, 1, 2, 0, 0, 0, 4'h0, 0, 0);
    #1;
    checkOutput("flush_ex_valid", 32'(a_ex_valid), 32'd0);
    checkOutput("flush_sel", 32'(a_rs_sel), 32'd0);
    checkOutput("flush_no_stall", 32'(a_stall), 32'd0);
    checkOutput("flush_cnt", 32'(a_stall_cnt), 32'd1);
    stepCycle();

    // Asynchronous reset in the middle of a stall
    applyStimulus(0, 1, 0, 0, 2, 1, 4'hF, 1, 0);
    stepCycle();
    applyStimulus(0, 1, 2, 0, 0, 0, 4'h0, 0, 0);
    #1 checkOutput("arst_pre_stall", 32'(a_stall), 32'd1);
    a_rst_n = 1'b0;
    #1;
    checkOutput("arst_stall", 32'(a_stall), 32'd0);
    checkOutput("arst_cnt", 32'(a_stall_cnt), 32'd0);
    checkOutput("arst_ex_valid", 32'(a_ex_valid), 32'd0);
    a_rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    stepCycle();

    // Random traffic against the model
    for (int a = 0; a < M_DEPTH; a++) pipe[a] = '{default: 0};
    m_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      r_valid = ($urandom_range(0, 3) != 0);
      r_rs = 5'($urandom_range(0, 7));
      r_rt = 5'($urandom_range(0, 7));
      r_rd = 5'($urandom_range(0, 7));
      r_we = ($urandom_range(0, 3) != 0);
      r_be = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      r_ld = ($urandom_range(0, 2) == 0);
      r_fl = ($urandom_range(0, 19) == 0);
      applyStimulus(0, r_valid, r_rs, r_rt, r_rd, r_we, r_be, r_ld, r_fl);
      #1;
      modelSel(r_rs, e_rs, blk_s);
      modelSel(r_rt, e_rt, blk_t);
      e_stall = r_valid && !r_fl && (blk_s || blk_t);
      checkOutput("rnd_stall", 32'(a_stall), 32'(e_stall));
      checkOutput("rnd_rs_sel", 32'(a_rs_sel), 32'(e_rs));
      checkOutput("rnd_rt_sel", 32'(a_rt_sel), 32'(e_rt));
      checkOutput("rnd_ex_valid", 32'(a_ex_valid), 32'(pipe[0].v));
      checkOutput("rnd_stall_cnt", 32'(a_stall_cnt), 32'(m_cnt));
      if (r_fl) begin
        for (int a = 0; a < M_DEPTH; a++) pipe[a] = '{default: 0};
      end else begin
        for (int a = M_DEPTH - 1; a > 0; a--) pipe[a] = pipe[a-1];
        if (e_stall) pipe[0] = '{default: 0};
        else pipe[0] = '{v: r_valid, rd: r_rd, we: r_we, be: r_be, ld: r_ld};
      end
      if (e_stall && m_cnt < 16'hFFFF) m_cnt++;
      stepCycle();
    end

    // DEPTH=5, LOAD_LAT=3: a load stalls its consumer for three cycles
    applyStimulus(1, 1, 0, 0, 9, 1, 4'hF, 1, 0);
    stepCycle();
    applyStimulus(1, 1, 9, 0, 0, 0, 4'h0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      #1 checkOutput("d5_stall", 32'(b_stall), 32'd1);
      stepCycle();
    end
    #1;
    checkOutput("d5_release", 32'(b_stall), 32'd0);
    checkOutput("d5_sel", 32'(b_rs_sel), 32'h924);
    checkOutput("d5_cnt", 32'(b_stall_cnt), 32'd3);
    stepCycle();

    // Saturation: a self-dependent load chain on DEPTH=16, LOAD_LAT=15
    // stalls 15 of every 16 cycles, which exceeds 65535 stalls in 70000 cycles.
    bc_rst_n = 1'b0;
    #1 bc_rst_n = 1'b1;
    applyStimulus(1, 1, 9, 0, 9, 1, 4'hF, 1, 0);
    repeat (70000) stepCycle();
    #1 checkOutput("sat_cnt", 32'(c_stall_cnt), 32'hFFFF);
    repeat (40) stepCycle();
    #1 checkOutput("sat_hold", 32'(c_stall_cnt), 32'hFFFF);
    bc_rst_n = 1'b0;
    #1;
    checkOutput("sat_reset_cnt", 32'(c_stall_cnt), 32'd0);
    checkOutput("sat_reset_stall", 32'(c_stall), 32'd0);
    checkOutput("d5_reset_cnt", 32'(b_stall_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
